sys_cmd_frame_tx: RTL and testbench

//  Host-side command framer for the system's UART command protocol. Takes one command

---
 rtl/sys_cmd_frame_tx.sv | 219 +++++++++++++++++++++
 tb/tb_sys_cmd_frame_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_frame_tx.sv
// rtl/sys_cmd_frame_tx.sv - UART command framer: sends one command frame, then collects its response
// Optional feature: define RSP_TIMEOUT_EN to bound each response-byte wait to TIMEOUT_CYC cycles.
module sys_cmd_frame_tx #(
  parameter int Data_Width  = 8,
  parameter int Addr_Width  = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                    REF_CLK,
  input  logic                    RST,
  input  logic                    CMD_VLD,
  input  logic [1:0]              CMD_OP,
  input  logic [Addr_Width-1:0]   CMD_ADDR,
  input  logic [Data_Width-1:0]   CMD_DATA,
  input  logic [Data_Width-1:0]   CMD_OPB,
  input  logic [3:0]              CMD_FUN,
  output logic                    CMD_BUSY,
  output logic [Data_Width-1:0]   TX_P_Data,
  output logic                    TX_D_VLD,
  input  logic                    TX_Busy,
  input  logic [Data_Width-1:0]   RX_P_Data,
  input  logic                    RX_D_VLD,
  output logic [2*Data_Width-1:0] RSP_Data,
  output logic                    RSP_VLD,
  output logic                    RSP_TIMEOUT
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO, S_RSP_LO, S_RSP_HI, S_DONE} state_t;

  localparam logic [1:0] OP_RF_WR = 2'd0;
  localparam logic [1:0] OP_RF_RD = 2'd1;
  localparam logic [1:0] OP_ALU   = 2'd2;
  localparam logic [Data_Width-1:0] HDR_WR  = Data_Width'(8'hAA);
  localparam logic [Data_Width-1:0] HDR_RD  = Data_Width'(8'hBB);
  localparam logic [Data_Width-1:0] HDR_ALU = Data_Width'(8'hCC);
  localparam logic [Data_Width-1:0] HDR_NOP = Data_Width'(8'hDD);

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d, idx_q, idx_d;
  logic [Addr_Width-1:0]   addr_q, addr_d;
  logic [Data_Width-1:0]   data_q, data_d, opb_q, opb_d, tx_data_q, tx_data_d;
  logic [3:0]              fun_q, fun_d;
  logic                    busy_q, busy_d, tx_vld_q, tx_vld_d, rsp_vld_q, rsp_vld_d;
  logic [2*Data_Width-1:0] rsp_q, rsp_d;
`ifdef RSP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    to_q, to_d;
`endif

  function automatic logic [Data_Width-1:0] frame_byte(
    input logic [1:0] op, input logic [1:0] idx, input logic [Addr_Width-1:0] addr,
    input logic [Data_Width-1:0] a, input logic [Data_Width-1:0] b, input logic [3:0] fun);
    logic [Data_Width-1:0] addr_x, fun_x, byte_v;
    addr_x = Data_Width'(addr);
    fun_x  = Data_Width'(fun);
    case (op)
      OP_RF_WR: byte_v = (idx == 2'd0) ? HDR_WR : (idx == 2'd1) ? addr_x : a;
      OP_RF_RD: byte_v = (idx == 2'd0) ? HDR_RD : addr_x;
      OP_ALU:   byte_v = (idx == 2'd0) ? HDR_ALU : (idx == 2'd1) ? a : (idx == 2'd2) ? b : fun_x;
      default:  byte_v = (idx == 2'd0) ? HDR_NOP : fun_x;
    endcase
    return byte_v;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] op);
    case (op)
      OP_RF_WR: last_idx = 2'd2;
      OP_ALU:   last_idx = 2'd3;
      default:  last_idx = 2'd1;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    opb_d     = opb_q;
    fun_d     = fun_q;
    busy_d    = busy_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    rsp_d     = rsp_q;
    rsp_vld_d = 1'b0;
`ifdef RSP_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (CMD_VLD) begin
        op_d      = CMD_OP;
        addr_d    = CMD_ADDR;
        data_d    = CMD_DATA;
        opb_d     = CMD_OPB;
        fun_d     = CMD_FUN;
        idx_d     = 2'd0;
        busy_d    = 1'b1;
        tx_vld_d  = 1'b1;
        tx_data_d = frame_byte(CMD_OP, 2'd0, CMD_ADDR, CMD_DATA, CMD_OPB, CMD_FUN);
        state_d   = S_SEND;
      end
      S_SEND: if (TX_Busy) begin
        tx_vld_d = 1'b0;
        state_d  = S_WAIT_HI;
      end
      S_WAIT_HI: state_d = S_WAIT_LO;
      S_WAIT_LO: if (!TX_Busy) begin
        if (idx_q != last_idx(op_q)) begin
          idx_d     = idx_q + 2'd1;
          tx_data_d = frame_byte(op_q, idx_q + 2'd1, addr_q, data_q, opb_q, fun_q);
          tx_vld_d  = 1'b1;
          state_d   = S_SEND;
        end else if (op_q == OP_RF_WR) begin
          rsp_vld_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_RSP_LO;
`ifdef RSP_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_RSP_LO: if (RX_D_VLD) begin
        rsp_d[Data_Width-1:0] = RX_P_Data;
        if (op_q == OP_RF_RD) begin
          rsp_d[2*Data_Width-1:Data_Width] = '0;
          rsp_vld_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_RSP_HI;
`ifdef RSP_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
`ifdef RSP_TIMEOUT_EN
      else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
        rsp_d     = '0;
        rsp_vld_d = 1'b1;
        to_d      = 1'b1;
        state_d   = S_DONE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`endif
      S_RSP_HI: if (RX_D_VLD) begin
        rsp_d[2*Data_Width-1:Data_Width] = RX_P_Data;
        rsp_vld_d = 1'b1;
        state_d   = S_DONE;
      end
`ifdef RSP_TIMEOUT_EN
      else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
        rsp_d[2*Data_Width-1:Data_Width] = '0;
        rsp_vld_d = 1'b1;
        to_d      = 1'b1;
        state_d   = S_DONE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      opb_q     <= '0;
      fun_q     <= '0;
      busy_q    <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      rsp_q     <= '0;
      rsp_vld_q <= 1'b0;
`ifdef RSP_TIMEOUT_EN
      cnt_q     <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      opb_q     <= opb_d;
      fun_q     <= fun_d;
      busy_q    <= busy_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      rsp_q     <= rsp_d;
      rsp_vld_q <= rsp_vld_d;
`ifdef RSP_TIMEOUT_EN
      cnt_q     <= cnt_d;
      to_q      <= to_d;
`endif
    end
  end

  assign CMD_BUSY  = busy_q;
  assign TX_P_Data = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign RSP_Data  = rsp_q;
  assign RSP_VLD   = rsp_vld_q;
`ifdef RSP_TIMEOUT_EN
  assign RSP_TIMEOUT = to_q;
`else
  assign RSP_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_sys_cmd_frame_tx.sv
// tb/tb_sys_cmd_frame_tx.sv - self-checking bench for sys_cmd_frame_tx with UART TX/RX models
// Timeout scenario runs only when RSP_TIMEOUT_EN is defined.
module tb_sys_cmd_frame_tx;

  logic        REF_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VLD = 1'b0;
  logic [1:0]  CMD_OP = '0;
  logic [3:0]  CMD_ADDR = '0;
  logic [7:0]  CMD_DATA = '0;
  logic [7:0]  CMD_OPB = '0;
  logic [3:0]  CMD_FUN = '0;
  logic        CMD_BUSY;
  logic [7:0]  TX_P_Data;
  logic        TX_D_VLD;
  logic        TX_Busy = 1'b0;
  logic [7:0]  RX_P_Data = '0;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] RSP_Data;
  logic        RSP_VLD;
  logic        RSP_TIMEOUT;

  int vectors = 0;
  int miscompares = 0;
  int tx_len = 4;
  int busy_cnt = 0;
  logic [7:0]  tx_q[$];
  logic [15:0] rsp_model = '0;

  sys_cmd_frame_tx dut (
    .REF_CLK(REF_CLK), .RST(RST), .CMD_VLD(CMD_VLD), .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR),
    .CMD_DATA(CMD_DATA), .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN), .CMD_BUSY(CMD_BUSY),
    .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy), .RX_P_Data(RX_P_Data),
    .RX_D_VLD(RX_D_VLD), .RSP_Data(RSP_Data), .RSP_VLD(RSP_VLD), .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  always #5 REF_CLK = ~REF_CLK;

  // UART TX model: takes a byte when idle and TX_D_VLD is high, then stays busy tx_len cycles.
  always @(negedge REF_CLK) begin
    if (RST) begin
      busy_cnt = 0;
      TX_Busy  = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      TX_Busy  = (busy_cnt != 0);
    end else if (TX_D_VLD) begin
      tx_q.push_back(TX_P_Data);
      busy_cnt = tx_len;
      TX_Busy  = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] a,
                             input logic [7:0] b, input logic [3:0] fun,
                             output logic [7:0] f[4], output int n);
    f = '{default: 8'h00};
    case (op)
      2'd0: begin f[0] = 8'hAA; f[1] = {4'h0, addr}; f[2] = a; n = 3; end
      2'd1: begin f[0] = 8'hBB; f[1] = {4'h0, addr}; n = 2; end
      2'd2: begin f[0] = 8'hCC; f[1] = a; f[2] = b; f[3] = {4'h0, fun}; n = 4; end
      default: begin f[0] = 8'hDD; f[1] = {4'h0, fun}; n = 2; end
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] fun, input logic [7:0] first);
    @(negedge REF_CLK);
    tx_q.delete();
    CMD_OP = op; CMD_ADDR = addr; CMD_DATA = a; CMD_OPB = b; CMD_FUN = fun;
    CMD_VLD = 1'b1;
    @(negedge REF_CLK);
    CMD_VLD = 1'b0;
    chk("accept_tx_vld", TX_D_VLD, 1);
    chk("accept_busy", CMD_BUSY, 1);
    chk("accept_byte0", TX_P_Data, first);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] fun, input logic [7:0] rlo,
                         input logic [7:0] rhi, input bit reply, input bit mid_pulse);
    logic [7:0]  f[4];
    int          n, nrx, stage, wait_c;
    bit          got;
    logic [15:0] exp_rsp;
    build_frame(op, addr, a, b, fun, f, n);
    nrx = (op == 2'd0) ? 0 : (op == 2'd1) ? 1 : 2;
    if (nrx == 0)      exp_rsp = rsp_model;
    else if (!reply)   exp_rsp = 16'h0000;
    else if (nrx == 1) exp_rsp = {8'h00, rlo};
    else               exp_rsp = {rhi, rlo};
    issue(op, addr, a, b, fun, f[0]);
    stage = (nrx != 0 && reply) ? 0 : 9;
    wait_c = 0;
    got = 0;
    for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
      @(negedge REF_CLK);
      RX_D_VLD = 1'b0;
      CMD_VLD  = 1'b0;
      if (RSP_VLD) got = 1;
      else begin
        if (cyc == 1) begin RX_P_Data = 8'hEE; RX_D_VLD = 1'b1; end
        if (mid_pulse && cyc == 3) begin CMD_OP = 2'd0; CMD_VLD = 1'b1; end
        case (stage)
          0: if (tx_q.size() == n && !TX_Busy) begin stage = 1; wait_c = 2 + $urandom_range(0, 4); end
          1: if (wait_c == 0) begin
               RX_P_Data = rlo; RX_D_VLD = 1'b1;
               stage = (nrx == 2) ? 2 : 9;
               wait_c = $urandom_range(0, 3);
             end else wait_c--;
          2: if (wait_c == 0) begin RX_P_Data = rhi; RX_D_VLD = 1'b1; stage = 9; end
             else wait_c--;
          default: ;
        endcase
      end
    end
    chk("rsp_vld_seen", got, 1);
    if (got) begin
      chk("rsp_data", RSP_Data, exp_rsp);
      chk("rsp_timeout", RSP_TIMEOUT, (nrx != 0 && !reply));
      chk("busy_at_done", CMD_BUSY, 1);
      chk("tx_count", tx_q.size(), n);
      for (int i = 0; i < n && i < tx_q.size(); i++) chk($sformatf("tx_byte%0d", i), tx_q[i], f[i]);
      @(negedge REF_CLK);
      chk("rsp_vld_one_cycle", RSP_VLD, 0);
      chk("busy_drop", CMD_BUSY, 0);
      chk("timeout_one_cycle", RSP_TIMEOUT, 0);
    end
    rsp_model = exp_rsp;
    if (mid_pulse) begin
      repeat (20) @(negedge REF_CLK);
      chk("dropped_req_no_tx", tx_q.size(), n);
      chk("dropped_req_idle", CMD_BUSY, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge REF_CLK);
    chk("rst_busy", CMD_BUSY, 0);
    chk("rst_tx_vld", TX_D_VLD, 0);
    chk("rst_tx_data", TX_P_Data, 0);
    chk("rst_rsp_vld", RSP_VLD, 0);
    chk("rst_rsp_data", RSP_Data, 0);
    chk("rst_timeout", RSP_TIMEOUT, 0);
    RST = 1'b0;
    @(negedge REF_CLK);

    tx_len = 10;
    run_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
    tx_len = 4;
    run_cmd(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 8'h7E, 8'h00, 1'b1, 1'b0);
    run_cmd(2'd2, 4'h0, 8'h0F, 8'h03, 4'h2, 8'h2D, 8'h00, 1'b1, 1'b0);
    tx_len = 10;
    run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h8, 8'h5A, 8'hA5, 1'b1, 1'b1);
    tx_len = 3;
    run_cmd(2'd0, 4'hF, 8'hFF, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
`ifdef RSP_TIMEOUT_EN
    run_cmd(2'd1, 4'h9, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
`endif

    // Reset in the middle of an ALU_OP frame
    tx_len = 5;
    issue(2'd2, 4'h0, 8'h11, 8'h22, 4'h3, 8'hCC);
    for (int c = 0; c < 500 && tx_q.size() < 2; c++) @(negedge REF_CLK);
    chk("rst_mid_reached", tx_q.size() >= 2, 1);
    RST = 1'b1;
    @(negedge REF_CLK);
    chk("mid_rst_busy", CMD_BUSY, 0);
    chk("mid_rst_tx_vld", TX_D_VLD, 0);
    chk("mid_rst_tx_data", TX_P_Data, 0);
    chk("mid_rst_rsp_vld", RSP_VLD, 0);
    chk("mid_rst_rsp_data", RSP_Data, 0);
    @(negedge REF_CLK);
    RST = 1'b0;
    rsp_model = '0;
    run_cmd(2'd1, 4'hA, 8'h00, 8'h00, 4'h0, 8'hC3, 8'h00, 1'b1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      tx_len = $urandom_range(1, 12);
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 8'($urandom),
              4'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
